mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter that shares the single-port `SIMPLE_RAM_bb` instance between the pipeline memory stage (port A) and a secondary requester such as the program loader or I/O DMA (port B). Each cycle it grants at most one access and drives the RAM address, data, rden and wren pins. It returns read data to the granted port with the RAM's fixed one-cycle read latency. It sits between the p4 memory stage and the RAM; the p4 stage stalls on `a_ready` low.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `RR_MODE`, 1: 1 selects round-robin; 0 selects fixed priority to port A with a starvation guard.
- `STARVE_LIMIT`, 4: applies when `RR_MODE`=0. After this many consecutive cycles in which port B requests and is denied, B wins the next contention. Legal range 1..15.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `a_req` / `b_req` in 1: access request, held until accepted.
- `a_we` / `b_we` in 1: 1 = write, 0 = read. Qualified by req.
- `a_addr` / `b_addr` in ADDR_W: word address.
- `a_wdata` / `b_wdata` in DATA_W: store data.
- `a_ready` / `b_ready` out 1: grant. The request is accepted in any cycle where req and ready are both high at the rising edge.
- `a_rvalid` / `b_rvalid` out 1: read data valid for that port this cycle.
- `a_rdata` / `b_rdata` out DATA_W: read data, meaningful only while rvalid is high.
- `ram_address` out ADDR_W; `ram_data` out DATA_W; `ram_rden` out 1; `ram_wren` out 1: drive the RAM.
- `ram_q` in DATA_W: RAM output. It is valid in the cycle after the edge that sampled address and rden.

## Operation
- Grant logic is combinational from the current req inputs and registered state. At most one of `a_ready`/`b_ready` is high.
- When only one port requests, that port is granted.
- When both ports request:
  - `RR_MODE`=1: grant the port that did not win the last contention. The `last_winner` register resets to B, so A wins the first contention.
  - `RR_MODE`=0: grant A, unless `starve_cnt` equals `STARVE_LIMIT`, in which case grant B.
- `starve_cnt` (4-bit) updates per cycle:
  - Increments when B requests and is not granted.
  - Clears when B is granted or B does not request.
  - Saturates at `STARVE_LIMIT`.
- The RAM pins follow the granted port's addr, wdata and we:
  - `ram_wren` = grant & we.
  - `ram_rden` = grant & ~we.
  - With no grant, both are 0, and address and data hold their previous values.
- Read return:
  - A registered 2-bit tag {valid, port} records each accepted read.
  - In the next cycle, the tagged port's rvalid is high and its rdata equals `ram_q`.
  - The other port's rdata is driven to 0.
- Writes produce no rvalid.
- Write data is in RAM at the accepting edge. A read of the same address accepted at the following edge returns the new value.

## Timing
- Reset values:
  - Outputs: all ready = 0, all rvalid = 0, all rdata = 0, `ram_rden` = `ram_wren` = 0, `ram_address` = 0, `ram_data` = 0.
  - State: `last_winner` = B, `starve_cnt` = 0, tag = invalid.
- While `reset` is high, grants are forced to 0.
- Reset asserted mid-operation:
  - A read accepted at the edge where reset is sampled high is discarded, and no rvalid follows.
  - The first grant is possible in the first cycle after reset deasserts.
- Latency:
  - Grant appears in the same cycle as req (zero-cycle accept when uncontended).
  - Read data follows 1 cycle after acceptance.
- Throughput: one access per cycle. Back-to-back reads from one port give rvalid high on consecutive cycles.
- Contention:
  - The loser's ready stays low. The loser must hold addr, we and wdata stable until ready.
  - The arbiter never drops a held request.
- Simultaneous events:
  - An rvalid for port X and a new grant to port X may coincide.
  - rvalid to one port and ready to the other may coincide.
- A req deasserted before acceptance is not an error. Nothing is issued.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults.
  - `port_t` enum {PORT_A, PORT_B}.
  - The `rd_tag_t` struct {logic valid; port_t port;}.
- Sub-module `arb_grant_logic` holds the winner selection, `last_winner`, and the starvation counter. Its ports: the two reqs in, the two grants out, plus clock and reset.
- The top level contains the RAM pin mux and the read-tag pipeline. The RAM itself is instantiated outside the block.

## Test plan
- Uncontended:
  - Stimulus: A writes 0x1234 to address 0x0010, then reads 0x0010.
  - Required: `a_ready` is high both cycles. `a_rvalid` is high exactly one cycle after the read with `a_rdata`=0x1234. `b_rvalid` stays 0.
- Round-robin (`RR_MODE`=1):
  - Stimulus: A and B both hold read req for 6 cycles.
  - Required: grant sequence A,B,A,B,A,B. rvalid alternates with 1-cycle lag, and each port's rdata matches its own address contents.
- Starvation (`RR_MODE`=0, `STARVE_LIMIT`=4):
  - Stimulus: both request continuously.
  - Required: grants A,A,A,A,B,A,A,A,A,B. `starve_cnt` returns to 0 after each B grant.
- Write-then-read across ports:
  - Stimulus: A writes 0xBEEF to 0x0200 in cycle N; B reads 0x0200 in cycle N+1.
  - Required: `b_rdata`=0xBEEF with `b_rvalid` in cycle N+2.
- Reset mid-read:
  - Stimulus: B read accepted at the same edge where `reset` is sampled high.
  - Required: no `b_rvalid`. All outputs are at reset values the next cycle. A wins the first contention after reset.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: `ram_rden`=`ram_wren`=0 throughout, `ram_address` held, no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and default widths for the RAM port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_ADDR_W = 16;
    localparam int unsigned c_DATA_W = 16;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/arb_grant_logic.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_logic
// Purpose  : Winner selection between ports A and B (round-robin or
//            A-priority with a B starvation guard).
// Revision : 1.0  initial release
// ============================================================================
module arb_grant_logic
    import mem_arb_pkg::*;
#(
    parameter bit          RR_MODE      = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    port_t      last_winner_q, last_winner_d;
    logic [3:0] starve_cnt_q,  starve_cnt_d;
    logic       w_contend;
    logic       w_b_wins;

    always_comb begin
        w_contend = a_req & b_req;
        if (RR_MODE) begin
            w_b_wins = (last_winner_q == PORT_A);
        end else begin
            w_b_wins = (starve_cnt_q == c_LIMIT);
        end

        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (w_contend) begin
                a_gnt = ~w_b_wins;
                b_gnt = w_b_wins;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // Only contended cycles decide who goes next; solo grants leave history alone.
    always_comb begin
        last_winner_d = last_winner_q;
        if (w_contend && !reset) begin
            last_winner_d = b_gnt ? PORT_B : PORT_A;
        end

        starve_cnt_d = 4'd0;
        if (b_req && !b_gnt) begin
            starve_cnt_d = (starve_cnt_q == c_LIMIT) ? c_LIMIT : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner_q <= PORT_B;
            starve_cnt_q  <= 4'd0;
        end else begin
            last_winner_q <= last_winner_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port RAM between the pipeline (A) and a
//            secondary requester (B); muxes RAM pins and routes read data.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = c_ADDR_W,
    parameter int unsigned DATA_W       = c_DATA_W,
    parameter bit          RR_MODE      = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    rd_tag_t           tag_q, tag_d;

    arb_grant_logic #(
        .RR_MODE      (RR_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clock (clock),
        .reset (reset),
        .a_req (a_req),
        .b_req (b_req),
        .a_gnt (w_a_gnt),
        .b_gnt (w_b_gnt)
    );

    // Pins follow the winner combinationally so an uncontended access is taken this cycle.
    always_comb begin
        ram_address = addr_q;
        ram_data    = data_q;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        if (w_a_gnt) begin
            ram_address = a_addr;
            ram_data    = a_wdata;
            ram_wren    = a_we;
            ram_rden    = ~a_we;
        end else if (w_b_gnt) begin
            ram_address = b_addr;
            ram_data    = b_wdata;
            ram_wren    = b_we;
            ram_rden    = ~b_we;
        end
    end

    always_comb begin
        tag_d.valid = (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);
        tag_d.port  = w_b_gnt ? PORT_B : PORT_A;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '{valid: 1'b0, port: PORT_A};
        end else begin
            addr_q <= ram_address;
            data_q <= ram_data;
            tag_q  <= tag_d;
        end
    end

    always_comb begin
        a_ready  = w_a_gnt;
        b_ready  = w_b_gnt;
        a_rvalid = tag_q.valid && (tag_q.port == PORT_A);
        b_rvalid = tag_q.valid && (tag_q.port == PORT_B);
        a_rdata  = a_rvalid ? ram_q : '0;
        b_rdata  = b_rvalid ? ram_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench; a round-robin and a fixed-priority
//            instance share stimulus, each with its own RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

    logic        rr_a_ready, rr_a_rvalid, rr_b_ready, rr_b_rvalid, rr_rden, rr_wren;
    logic [15:0] rr_a_rdata, rr_b_rdata, rr_addr, rr_data, rr_q;
    logic        fp_a_ready, fp_a_rvalid, fp_b_ready, fp_b_rvalid, fp_rden, fp_wren;
    logic [15:0] fp_a_rdata, fp_b_rdata, fp_addr, fp_data, fp_q;

    logic [15:0] mem_rr [0:65535];
    logic [15:0] mem_fp [0:65535];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_MODE(1'b1), .STARVE_LIMIT(4)) u_rr (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(rr_a_ready), .a_rvalid(rr_a_rvalid), .a_rdata(rr_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(rr_b_ready), .b_rvalid(rr_b_rvalid), .b_rdata(rr_b_rdata),
        .ram_address(rr_addr), .ram_data(rr_data), .ram_rden(rr_rden),
        .ram_wren(rr_wren), .ram_q(rr_q)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_MODE(1'b0), .STARVE_LIMIT(4)) u_fp (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(fp_a_ready), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(fp_b_ready), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
        .ram_address(fp_addr), .ram_data(fp_data), .ram_rden(fp_rden),
        .ram_wren(fp_wren), .ram_q(fp_q)
    );

    always @(posedge clock) begin
        if (rr_wren) mem_rr[rr_addr] <= rr_data;
        if (rr_rden) rr_q <= mem_rr[rr_addr];
        if (fp_wren) mem_fp[fp_addr] <= fp_data;
        if (fp_rden) fp_q <= mem_fp[fp_addr];
    end

    function automatic logic [15:0] init_val(input logic [15:0] addr);
        return addr ^ 16'hC3A5;
    endfunction

    task automatic set_in(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                          input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 16'h0005, 16'h1111, 1'b1, 1'b0, 16'h0006, 16'h2222);
        #1;
        n_vec++;
        if ({rr_a_ready, rr_b_ready, fp_a_ready, fp_b_ready} !== 4'b0000) begin
            n_err++; $display("FAIL reset_grant: got %b expected 0000", {rr_a_ready, rr_b_ready, fp_a_ready, fp_b_ready});
        end
        n_vec++;
        if ({rr_a_rvalid, rr_b_rvalid, rr_rden, rr_wren} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {rr_a_rvalid, rr_b_rvalid, rr_rden, rr_wren});
        end
        n_vec++;
        if ({rr_addr, rr_data, rr_a_rdata, rr_b_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", {rr_addr, rr_data, rr_a_rdata, rr_b_rdata});
        end
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_uncontended();
        set_in(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        n_vec++;
        if ({rr_a_ready, rr_wren, rr_rden} !== 3'b110 || rr_addr !== 16'h0010) begin
            n_err++; $display("FAIL unc_write: got rdy/wr/rd=%b addr=%h expected 110 0010", {rr_a_ready, rr_wren, rr_rden}, rr_addr);
        end
        cyc();
        a_we = 1'b0;
        #1;
        n_vec++;
        if ({rr_a_ready, rr_rden, rr_a_rvalid} !== 3'b110) begin
            n_err++; $display("FAIL unc_read_issue: got %b expected 110", {rr_a_ready, rr_rden, rr_a_rvalid});
        end
        cyc();
        a_req = 1'b0;
        #1;
        n_vec++;
        if (rr_a_rvalid !== 1'b1 || rr_a_rdata !== 16'h1234 || rr_b_rvalid !== 1'b0) begin
            n_err++; $display("FAIL unc_read_data: got av=%b ad=%h bv=%b expected 1 1234 0", rr_a_rvalid, rr_a_rdata, rr_b_rvalid);
        end
        cyc();
        #1;
        n_vec++;
        if (rr_a_rvalid !== 1'b0 || rr_a_rdata !== 16'h0) begin
            n_err++; $display("FAIL unc_rvalid_drop: got av=%b ad=%h expected 0 0000", rr_a_rvalid, rr_a_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        set_in(1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin a_req = 1'b0; b_req = 1'b0; end
            #1;
            if (k < 6) begin
                exp_a = (k % 2 == 0);
                n_vec++;
                if (rr_a_ready !== exp_a || rr_b_ready !== !exp_a) begin
                    n_err++; $display("FAIL rr_grant[%0d]: got a=%b b=%b expected a=%b", k, rr_a_ready, rr_b_ready, exp_a);
                end
            end
            if (k > 0) begin
                exp_a = ((k - 1) % 2 == 0);
                n_vec++;
                if (rr_a_rvalid !== exp_a || rr_b_rvalid !== !exp_a ||
                    (exp_a ? rr_a_rdata : rr_b_rdata) !== init_val(exp_a ? 16'h0100 : 16'h0300)) begin
                    n_err++; $display("FAIL rr_rdata[%0d]: got av=%b bv=%b ad=%h bd=%h expected av=%b", k,
                                      rr_a_rvalid, rr_b_rvalid, rr_a_rdata, rr_b_rdata, exp_a);
                end
            end
            cyc();
        end
    endtask

    task automatic test_starvation();
        logic exp_b;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        reset = 1'b0;
        set_in(1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int k = 0; k < 11; k++) begin
            if (k == 10) begin a_req = 1'b0; b_req = 1'b0; end
            #1;
            if (k < 10) begin
                exp_b = (k % 5 == 4);
                n_vec++;
                if (fp_a_ready !== !exp_b || fp_b_ready !== exp_b) begin
                    n_err++; $display("FAIL starve_grant[%0d]: got a=%b b=%b expected b=%b", k, fp_a_ready, fp_b_ready, exp_b);
                end
            end
            n_vec++;
            if (u_fp.u_grant.starve_cnt_q !== 4'(k % 5)) begin
                n_err++; $display("FAIL starve_cnt[%0d]: got %0d expected %0d", k, u_fp.u_grant.starve_cnt_q, k % 5);
            end
            cyc();
        end
    endtask

    task automatic test_write_then_read();
        set_in(1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        n_vec++;
        if (rr_a_ready !== 1'b1 || rr_wren !== 1'b1) begin
            n_err++; $display("FAIL wr_rd_write: got rdy=%b wren=%b expected 1 1", rr_a_ready, rr_wren);
        end
        cyc();
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        #1;
        n_vec++;
        if (rr_b_ready !== 1'b1 || rr_rden !== 1'b1 || rr_a_rvalid !== 1'b0) begin
            n_err++; $display("FAIL wr_rd_issue: got brdy=%b rden=%b av=%b expected 1 1 0", rr_b_ready, rr_rden, rr_a_rvalid);
        end
        cyc();
        b_req = 1'b0;
        #1;
        n_vec++;
        if (rr_b_rvalid !== 1'b1 || rr_b_rdata !== 16'hBEEF || rr_a_rvalid !== 1'b0 || rr_a_rdata !== 16'h0) begin
            n_err++; $display("FAIL wr_rd_data: got bv=%b bd=%h av=%b ad=%h expected 1 beef 0 0000",
                              rr_b_rvalid, rr_b_rdata, rr_a_rvalid, rr_a_rdata);
        end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        // A wins this contention, so without a reset B would win the next one.
        set_in(1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
        #1;
        n_vec++;
        if (rr_a_ready !== 1'b1 || rr_b_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_pre_grant: got a=%b b=%b expected 1 0", rr_a_ready, rr_b_ready);
        end
        cyc();
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        n_vec++;
        if (rr_b_ready !== 1'b0 || rr_rden !== 1'b0) begin
            n_err++; $display("FAIL rst_forced_grant: got brdy=%b rden=%b expected 0 0", rr_b_ready, rr_rden);
        end
        cyc();
        reset = 1'b0;
        b_req = 1'b0;
        #1;
        n_vec++;
        if ({rr_a_ready, rr_b_ready, rr_a_rvalid, rr_b_rvalid, rr_rden, rr_wren} !== 6'b0 ||
            {rr_addr, rr_data, rr_a_rdata, rr_b_rdata} !== 64'h0) begin
            n_err++; $display("FAIL rst_values: got ctl=%b data=%h expected all zero",
                              {rr_a_ready, rr_b_ready, rr_a_rvalid, rr_b_rvalid, rr_rden, rr_wren},
                              {rr_addr, rr_data, rr_a_rdata, rr_b_rdata});
        end
        cyc();
        set_in(1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
        #1;
        n_vec++;
        if (rr_a_ready !== 1'b1 || rr_b_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_first_contention: got a=%b b=%b expected 1 0", rr_a_ready, rr_b_ready);
        end
        cyc();
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        n_vec++;
        if (rr_a_rvalid !== 1'b1 || rr_a_rdata !== init_val(16'h0060)) begin
            n_err++; $display("FAIL rst_post_read: got av=%b ad=%h expected 1 %h", rr_a_rvalid, rr_a_rdata, init_val(16'h0060));
        end
        cyc();
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            #1;
            n_vec++;
            if ({rr_rden, rr_wren, rr_a_rvalid, rr_b_rvalid} !== 4'b0000 || rr_addr !== 16'h0060) begin
                n_err++; $display("FAIL idle[%0d]: got ctl=%b addr=%h expected 0000 0060", k,
                                  {rr_rden, rr_wren, rr_a_rvalid, rr_b_rvalid}, rr_addr);
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_rr[i] = init_val(16'(i));
            mem_fp[i] = init_val(16'(i));
        end
        reset = 1'b1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        test_reset();
        test_uncontended();
        test_round_robin();
        test_starvation();
        test_write_then_read();
        test_reset_mid_read();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
